// File: rtl/box_line_sched_if.sv
// box_line_sched_if -- descriptor write channel for box_line_sched.
//   master drives wr_req/wr_idx/wr_x1..wr_y2/wr_rgb/wr_en and holds wr_req
//   until it sees wr_ack; slave returns a one-cycle wr_ack pulse per write.
interface box_line_sched_if #(
   parameter int NBOX = 4
);
   localparam int IW = $clog2(NBOX);

   logic          wr_req;
   logic [IW-1:0] wr_idx;
   logic [10:0]   wr_x1;
   logic [10:0]   wr_y1;
   logic [10:0]   wr_x2;
   logic [10:0]   wr_y2;
   logic [2:0]    wr_rgb;
   logic          wr_en;
   logic          wr_ack;

   modport master (
      output wr_req, wr_idx, wr_x1, wr_y1, wr_x2, wr_y2, wr_rgb, wr_en,
      input  wr_ack
   );

   modport slave (
      input  wr_req, wr_idx, wr_x1, wr_y1, wr_x2, wr_y2, wr_rgb, wr_en,
      output wr_ack
   );
endinterface

// File: rtl/box_line_sched.sv
// box_line_sched -- per-scanline box descriptor scheduler.
//   Two banks of NBOX box descriptors: shadow (written over the wr channel)
//   and active (scanned). commit arms a shadow->active copy at the next
//   frame_start. On each line_start the active bank is scanned one slot per
//   cycle and the lowest-index box covering line_y is presented on box_*.
// Ports:
//   clk, reset        pixel clock, async active-high reset
//   frame_start       frame boundary pulse (performs pending copy, aborts scan)
//   line_start/line_y starts a scan of line line_y
//   wr                descriptor write channel (slave side)
//   commit            arms copy; commit_pending shows it is armed
//   box_*/box_valid   selected box for the draw datapath
//   busy              scan in progress
module box_line_sched #(
   parameter int NBOX = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            frame_start,
   input  logic            line_start,
   input  logic [10:0]     line_y,
   box_line_sched_if.slave wr,
   input  logic            commit,
   output logic            commit_pending,
   output logic [10:0]     box_x1,
   output logic [10:0]     box_y1,
   output logic [10:0]     box_x2,
   output logic [10:0]     box_y2,
   output logic [2:0]      box_rgb,
   output logic            box_valid,
   output logic            busy
);
   localparam int IW = $clog2(NBOX);

   typedef struct packed {
      logic [10:0] x1;
      logic [10:0] y1;
      logic [10:0] x2;
      logic [10:0] y2;
      logic [2:0]  rgb;
      logic        en;
   } desc_t;

   typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

   desc_t [NBOX-1:0] shadow;
   desc_t [NBOX-1:0] active;
   state_t           state, state_n;
   logic [IW-1:0]    idx;
   logic [10:0]      ly;
   logic             found;
   desc_t            hit_desc;
   desc_t            box_q;
   desc_t            cur;
   logic             copy, accept, last, cur_hit;

   // A copying frame_start owns the shadow bank for that cycle; a write
   // waiting on it is taken on the following cycle instead.
   assign copy    = frame_start & commit_pending;
   assign accept  = wr.wr_req & ~wr.wr_ack & ~copy;

   assign cur     = active[idx];
   // Unsigned compare: a slot with y1 > y2 can never satisfy both bounds.
   assign cur_hit = cur.en & (cur.y1 <= ly) & (ly <= cur.y2);
   assign last    = (idx == IW'(NBOX-1));

   // Descriptor banks, write handshake, commit tracking.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow         <= '0;
         active         <= '0;
         wr.wr_ack      <= 1'b0;
         commit_pending <= 1'b0;
      end else begin
         wr.wr_ack <= accept;
         if (accept)
            shadow[wr.wr_idx] <= '{wr.wr_x1, wr.wr_y1, wr.wr_x2, wr.wr_y2,
                                   wr.wr_rgb, wr.wr_en};
         if (copy)
            active <= shadow;
         // A commit landing on the copy cycle arms the next frame.
         commit_pending <= copy ? commit : (commit_pending | commit);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // line_start wins over frame_start: the copy lands on the same edge, so
   // the new scan already sees the new active bank.
   always_comb begin
      state_n = state;
      if (line_start)
         state_n = SCAN;
      else if (frame_start)
         state_n = IDLE;
      else if (state == SCAN && last)
         state_n = HOLD;
   end

   assign busy = (state == SCAN);

   // Scan datapath: first hit is latched; the last slot's hit is folded in
   // directly on the SCAN->HOLD edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx       <= '0;
         ly        <= '0;
         found     <= 1'b0;
         hit_desc  <= '0;
         box_q     <= '0;
         box_valid <= 1'b0;
      end else if (line_start) begin
         ly        <= line_y;
         idx       <= '0;
         found     <= 1'b0;
         box_valid <= 1'b0;
      end else if (frame_start) begin
         idx       <= '0;
         found     <= 1'b0;
         box_valid <= 1'b0;
      end else if (state == SCAN) begin
         idx <= idx + 1'b1;
         if (cur_hit && !found) begin
            found    <= 1'b1;
            hit_desc <= cur;
         end
         if (last) begin
            idx <= '0;
            // No hit: box_* keep their previous contents.
            if (found || cur_hit) begin
               box_q     <= found ? hit_desc : cur;
               box_valid <= 1'b1;
            end
         end
      end
   end

   assign box_x1  = box_q.x1;
   assign box_y1  = box_q.y1;
   assign box_x2  = box_q.x2;
   assign box_y2  = box_q.y2;
   assign box_rgb = box_q.rgb;
endmodule

// File: tb/tb_box_line_sched.sv
module tb_box_line_sched;
   localparam int NBOX = 4;

   logic        clk;
   logic        reset;
   logic        frame_start;
   logic        line_start;
   logic [10:0] line_y;
   logic        commit;
   logic        commit_pending;
   logic [10:0] box_x1, box_y1, box_x2, box_y2;
   logic [2:0]  box_rgb;
   logic        box_valid;
   logic        busy;

   box_line_sched_if #(.NBOX(NBOX)) wr_bus ();

   box_line_sched #(.NBOX(NBOX)) dut (
      .clk            (clk),
      .reset          (reset),
      .frame_start    (frame_start),
      .line_start     (line_start),
      .line_y         (line_y),
      .wr             (wr_bus),
      .commit         (commit),
      .commit_pending (commit_pending),
      .box_x1         (box_x1),
      .box_y1         (box_y1),
      .box_x2         (box_x2),
      .box_y2         (box_y2),
      .box_rgb        (box_rgb),
      .box_valid      (box_valid),
      .busy           (busy)
   );

   typedef struct {
      bit v;
      int x1, y1, x2, y2, rgb;
      int t0;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: a scan result is presented when busy drops outside reset.
   initial begin
      bit   prev_busy;
      exp_t e;
      prev_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset && prev_busy && !busy) begin
            if (q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_result: box_valid=%0d with no expectation", box_valid);
            end else begin
               e = q.pop_front();
               chk("box_valid", int'(box_valid), int'(e.v));
               chk("box_x1",    int'(box_x1),    e.x1);
               chk("box_y1",    int'(box_y1),    e.y1);
               chk("box_x2",    int'(box_x2),    e.x2);
               chk("box_y2",    int'(box_y2),    e.y2);
               chk("box_rgb",   int'(box_rgb),   e.rgb);
               chk("latency",   cyc - e.t0,      NBOX + 1);
            end
         end
         prev_busy = reset ? 1'b0 : busy;
      end
   end

   task automatic wr_slot(input int idx, input int x1, input int y1, input int x2,
                          input int y2, input int rgb, input bit en);
      bit got;
      @(negedge clk);
      wr_bus.wr_idx = 2'(idx);
      wr_bus.wr_x1  = 11'(x1);
      wr_bus.wr_y1  = 11'(y1);
      wr_bus.wr_x2  = 11'(x2);
      wr_bus.wr_y2  = 11'(y2);
      wr_bus.wr_rgb = 3'(rgb);
      wr_bus.wr_en  = en;
      wr_bus.wr_req = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(posedge clk);
         #1;
         got = wr_bus.wr_ack;
      end
      wr_bus.wr_req = 1'b0;
      if (!got) begin
         n_cmp++;
         n_err++;
         $display("FAIL wr_ack_timeout: no wr_ack for slot %0d", idx);
      end
   endtask

   task automatic pulse_commit();
      @(negedge clk);
      commit = 1'b1;
      @(negedge clk);
      commit = 1'b0;
   endtask

   task automatic pulse_frame();
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   task automatic do_line(input int y, input bit fs, input bit v, input int x1,
                          input int y1, input int x2, input int y2, input int rgb);
      exp_t e;
      @(negedge clk);
      line_y      = 11'(y);
      line_start  = 1'b1;
      frame_start = fs;
      e.v = v; e.x1 = x1; e.y1 = y1; e.x2 = x2; e.y2 = y2; e.rgb = rgb; e.t0 = cyc;
      q.push_back(e);
      @(negedge clk);
      line_start  = 1'b0;
      frame_start = 1'b0;
      for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL scan_timeout: no result for line %0d", y);
         q.delete();
      end
   endtask

   initial begin
      exp_t e;
      reset         = 1'b1;
      frame_start   = 1'b0;
      line_start    = 1'b0;
      line_y        = '0;
      commit        = 1'b0;
      wr_bus.wr_req = 1'b0;
      wr_bus.wr_idx = '0;
      wr_bus.wr_x1  = '0;
      wr_bus.wr_y1  = '0;
      wr_bus.wr_x2  = '0;
      wr_bus.wr_y2  = '0;
      wr_bus.wr_rgb = '0;
      wr_bus.wr_en  = 1'b0;

      // Reset state
      #22;
      chk("rst_box_valid", int'(box_valid), 0);
      chk("rst_box_x1", int'(box_x1), 0);
      chk("rst_wr_ack", int'(wr_bus.wr_ack), 0);
      chk("rst_commit_pending", int'(commit_pending), 0);
      chk("rst_busy", int'(busy), 0);
      @(negedge clk);
      reset = 1'b0;

      // Basic write/commit/frame/line
      wr_slot(1, 10, 20, 100, 50, 4, 1'b1);
      pulse_commit();
      chk("commit_pending_set", int'(commit_pending), 1);
      pulse_frame();
      chk("commit_pending_clr", int'(commit_pending), 0);
      do_line(20, 1'b0, 1'b1, 10, 20, 100, 50, 4);
      repeat (3) @(negedge clk);
      chk("hold_valid", int'(box_valid), 1);
      chk("hold_x1", int'(box_x1), 10);
      chk("hold_busy", int'(busy), 0);

      // commit on the copying frame_start stays armed; frame_start clears box_valid
      pulse_commit();
      @(negedge clk);
      commit = 1'b1;
      frame_start = 1'b1;
      @(negedge clk);
      commit = 1'b0;
      frame_start = 1'b0;
      chk("commit_rearmed", int'(commit_pending), 1);
      chk("frame_clears_valid", int'(box_valid), 0);
      pulse_frame();
      chk("commit_rearm_clr", int'(commit_pending), 0);

      // Inclusive lower/upper bounds
      do_line(51, 1'b0, 1'b0, 10, 20, 100, 50, 4);
      do_line(50, 1'b0, 1'b1, 10, 20, 100, 50, 4);

      // Priority: lowest index wins
      wr_slot(1, 10, 20, 100, 50, 4, 1'b0);
      wr_slot(0, 0, 25, 5, 35, 1, 1'b1);
      wr_slot(2, 200, 30, 300, 40, 2, 1'b1);
      pulse_commit();
      pulse_frame();
      do_line(30, 1'b0, 1'b1, 0, 25, 5, 35, 1);
      wr_slot(0, 0, 25, 5, 35, 1, 1'b0);
      pulse_commit();
      pulse_frame();
      do_line(30, 1'b0, 1'b1, 200, 30, 300, 40, 2);

      // Inverted box never hits; outputs hold last box
      wr_slot(2, 200, 30, 300, 40, 2, 1'b0);
      wr_slot(3, 7, 60, 8, 40, 5, 1'b1);
      pulse_commit();
      pulse_frame();
      do_line(40, 1'b0, 1'b0, 200, 30, 300, 40, 2);
      do_line(50, 1'b0, 1'b0, 200, 30, 300, 40, 2);
      do_line(60, 1'b0, 1'b0, 200, 30, 300, 40, 2);

      // Write without commit leaves active unchanged
      wr_slot(1, 10, 20, 100, 50, 4, 1'b1);
      pulse_frame();
      do_line(30, 1'b0, 1'b0, 200, 30, 300, 40, 2);
      pulse_commit();
      repeat (5) @(negedge clk);
      chk("commit_pending_waits", int'(commit_pending), 1);
      pulse_frame();
      chk("commit_pending_done", int'(commit_pending), 0);
      do_line(30, 1'b0, 1'b1, 10, 20, 100, 50, 4);

      // Write colliding with the copy cycle is deferred by one cycle
      pulse_commit();
      @(negedge clk);
      wr_bus.wr_idx = 2'd1;
      wr_bus.wr_x1  = 11'd11;
      wr_bus.wr_y1  = 11'd0;
      wr_bus.wr_x2  = 11'd12;
      wr_bus.wr_y2  = 11'd1000;
      wr_bus.wr_rgb = 3'd7;
      wr_bus.wr_en  = 1'b1;
      wr_bus.wr_req = 1'b1;
      frame_start   = 1'b1;
      @(posedge clk);
      #1;
      chk("defer_no_ack", int'(wr_bus.wr_ack), 0);
      chk("defer_copy_done", int'(commit_pending), 0);
      @(negedge clk);
      frame_start = 1'b0;
      @(posedge clk);
      #1;
      chk("defer_ack", int'(wr_bus.wr_ack), 1);
      wr_bus.wr_req = 1'b0;
      @(posedge clk);
      #1;
      chk("ack_one_cycle", int'(wr_bus.wr_ack), 0);
      do_line(30, 1'b0, 1'b1, 10, 20, 100, 50, 4);
      pulse_commit();
      pulse_frame();
      do_line(30, 1'b0, 1'b1, 11, 0, 12, 1000, 7);

      // line_start during SCAN restarts with the new line
      @(negedge clk);
      line_y = 11'd2000;
      line_start = 1'b1;
      @(negedge clk);
      line_start = 1'b0;
      @(negedge clk);
      line_y = 11'd30;
      line_start = 1'b1;
      e.v = 1'b1; e.x1 = 11; e.y1 = 0; e.x2 = 12; e.y2 = 1000; e.rgb = 7; e.t0 = cyc;
      q.push_back(e);
      @(negedge clk);
      line_start = 1'b0;
      for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL restart_timeout: no result after restart");
         q.delete();
      end

      // frame_start + line_start: copy first, scan the new bank
      wr_slot(1, 11, 0, 12, 1000, 7, 1'b0);
      wr_slot(3, 50, 0, 60, 2047, 3, 1'b1);
      pulse_commit();
      do_line(30, 1'b1, 1'b1, 50, 0, 60, 2047, 3);

      // Reset in the middle of a scan
      @(negedge clk);
      line_y = 11'd30;
      line_start = 1'b1;
      @(negedge clk);
      line_start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_box_x1", int'(box_x1), 0);
      chk("midrst_box_rgb", int'(box_rgb), 0);
      chk("midrst_box_valid", int'(box_valid), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_commit_pending", int'(commit_pending), 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("postrst_busy", int'(busy), 0);
      do_line(30, 1'b0, 1'b0, 0, 0, 0, 0, 0);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: bench did not complete");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/box_line_sched.md
BOX_LINE_SCHED -- requirements
Module: box_line_sched

Interface
Parameters:
REQ-001 The block SHALL have parameter NBOX, default 4, meaning the number of box descriptor slots (power of two, 2..8).
Ports:
REQ-002 The block SHALL have port clk, input, 1, the single pixel clock.
REQ-003 The block SHALL have port reset, input, 1, an asynchronous active-high reset.
REQ-004 The block SHALL have port frame_start, input, 1, a one-cycle pulse at frame boundary.
REQ-005 The block SHALL have port line_start, input, 1, a one-cycle pulse at horizontal blanking start.
REQ-006 The block SHALL have port line_y, input, 11, the offset-corrected scanline index, sampled on line_start.
REQ-007 The block SHALL have port wr_req, input, 1, the descriptor write request, held until wr_ack.
REQ-008 The block SHALL have port wr_idx, input, log2(NBOX), the target slot.
REQ-009 The block SHALL have ports wr_x1/wr_y1/wr_x2/wr_y2, input, 11 each, the box corners.
REQ-010 The block SHALL have port wr_rgb, input, 3, the {r,g,b} colour bits.
REQ-011 The block SHALL have port wr_en, input, 1, the slot enable bit.
REQ-012 The block SHALL have port wr_ack, output, 1, a one-cycle write acceptance pulse.
REQ-013 The block SHALL have port commit, input, 1, a pulse requesting shadow-to-active copy at the next frame_start.
REQ-014 The block SHALL have port commit_pending, output, 1, high while a commit awaits frame_start.
REQ-015 The block SHALL have ports box_x1/box_y1/box_x2/box_y2, output, 11 each, the coordinates for the box draw datapath.
REQ-016 The block SHALL have port box_rgb, output, 3, the colour for the draw datapath.
REQ-017 The block SHALL have port box_valid, output, 1, high when the outputs hold a box covering the current line.
REQ-018 The block SHALL have port busy, output, 1, high during the scan state.

Function
REQ-019 The block SHALL hold two register banks of NBOX descriptors {x1,y1,x2,y2,rgb,en}: shadow (writable) and active (scanned).
REQ-020 A write SHALL be accepted in any cycle with wr_req=1, wr_ack=0 and no copy in progress; the shadow[wr_idx] update and the wr_ack pulse SHALL occur on the next edge.
REQ-021 A wr_req that coincides with a frame_start copy SHALL be deferred one cycle; the copy SHALL use the pre-write shadow contents.
REQ-022 commit SHALL set commit_pending; frame_start with commit_pending=1 SHALL copy all shadow slots to active in one cycle and clear commit_pending.
REQ-023 commit coincident with a copying frame_start SHALL leave commit_pending=1 for the following frame.
REQ-024 frame_start without pending SHALL leave the active bank unchanged.
REQ-025 The FSM SHALL have states IDLE, SCAN, and HOLD.
REQ-026 IDLE/HOLD + line_start SHALL latch line_y, set idx=0, clear the hit flag, and go to SCAN.
REQ-027 SCAN SHALL test one slot per cycle: hit = en & (y1 <= line_y) & (line_y <= y2), unsigned 11-bit.
REQ-028 SCAN SHALL latch only the first, lowest-index, hit.
REQ-029 SCAN SHALL go to HOLD after idx=NBOX-1.
REQ-030 Descriptors with y1 > y2 SHALL never hit.
REQ-031 On SCAN->HOLD the block SHALL drive box_* from the latched hit and set box_valid=1. With no hit, box_valid=0 and box_* SHALL hold their previous values.
REQ-032 Outputs SHALL be valid NBOX+1 cycles after line_start. box_* and box_valid SHALL be stable through HOLD.
REQ-033 line_start during SCAN SHALL restart the scan with the new line_y (idx=0).
REQ-034 frame_start in any state SHALL clear box_valid and force IDLE. If line_start coincides, the copy SHALL happen first and the scan SHALL start on the new active bank with the new line_y.
REQ-035 busy SHALL equal (state==SCAN).

Reset
REQ-036 While reset is high, all shadow/active slots SHALL be cleared (en=0, coords 0, rgb 0), the state SHALL be IDLE, and idx SHALL be 0.
REQ-037 While reset is high, box_* = 0, box_rgb = 0, box_valid = 0, wr_ack = 0, commit_pending = 0, and busy = 0, regardless of clk.
REQ-038 Reset asserted mid-SCAN or mid-write SHALL abandon the operation with no partial slot update after release.

Verification
REQ-039 Write slot1 {x1=10,y1=20,x2=100,y2=50,rgb=3'b100,en=1}, commit, frame_start, line_start with line_y=20 -> after 5 cycles box_valid=1, box_x1=10, box_y2=50, box_rgb=100.
REQ-040 Slots 0 and 2 both enabled covering y=30, line_start with y=30 -> slot0 is output; disable slot0, commit, frame_start, same line -> slot2 is output.
REQ-041 line_y=51 against slot1 only (y2=50) -> box_valid=0; line_y=50 -> box_valid=1 (inclusive bound); slot y1=60, y2=40 -> never valid.
REQ-042 Write without commit, then frame_start -> active unchanged, old box still output; commit alone -> commit_pending=1 until the next frame_start.
REQ-043 wr_req held in the frame_start copy cycle -> wr_ack is delayed one cycle, the copied active slot holds the old value, and the shadow holds the new value.
REQ-044 Reset pulse during SCAN at idx=2 -> all outputs 0 immediately, IDLE after release, and the next line_start yields box_valid=0 (all slots cleared).
